// File: rtl/tf32_pkg.sv
// rtl/tf32_pkg.sv - TF32 format constants and accumulator FSM state type
package tf32_pkg;

    localparam int TF32_W = 19;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 10;
    localparam int BIAS   = 127;

    localparam logic [TF32_W-1:0] TF32_POS_ZERO = 19'h00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tf32_add.sv
// rtl/tf32_add.sv - combinational TF32 adder, round-to-nearest-even, normals only
//
// Ports:
//   operand_A, operand_B : TF32 inputs ([18] sign, [17:10] exp, [9:0] mantissa)
//   result               : TF32 sum; zero results are +0, underflow flushes to +0,
//                          overflow returns signed infinity
module TF32_add
    import tf32_pkg::*;
(
    input  logic [TF32_W-1:0] operand_A,
    input  logic [TF32_W-1:0] operand_B,
    output logic [TF32_W-1:0] result
);

    logic               swap;
    logic [TF32_W-1:0]  big;
    logic [TF32_W-1:0]  sml;
    logic [EXP_W-1:0]   e_big;
    logic [EXP_W-1:0]   e_sml;
    logic [EXP_W-1:0]   diff;
    logic [MAN_W:0]     sig_big;
    logic [MAN_W:0]     sig_sml;
    logic [MAN_W+3:0]   ext_big;
    logic [MAN_W+3:0]   ext_sml;
    logic [MAN_W+3:0]   aligned;
    logic [MAN_W+4:0]   sum;
    logic [MAN_W+3:0]   norm;
    logic               round_up;
    logic [MAN_W+1:0]   mant_r;
    logic [MAN_W-1:0]   mant;
    int                 lead;
    int                 exp_i;

    always_comb begin
        // Order operands by magnitude so the subtraction below never goes negative.
        swap    = operand_B[TF32_W-2:0] > operand_A[TF32_W-2:0];
        big     = swap ? operand_B : operand_A;
        sml     = swap ? operand_A : operand_B;
        e_big   = big[TF32_W-2:MAN_W];
        e_sml   = sml[TF32_W-2:MAN_W];
        diff    = e_big - e_sml;
        sig_big = (e_big != '0) ? {1'b1, big[MAN_W-1:0]} : '0;
        sig_sml = (e_sml != '0) ? {1'b1, sml[MAN_W-1:0]} : '0;

        // Three extra bits: guard, round, and a sticky bit collecting everything shifted out.
        ext_big = {sig_big, 3'b000};
        ext_sml = {sig_sml, 3'b000};
        if (diff >= 8'd14) begin
            aligned = {13'd0, |sig_sml};
        end else begin
            aligned = (ext_sml >> diff) |
                      {13'd0, |(ext_sml & ((14'd1 << diff) - 14'd1))};
        end

        if (big[TF32_W-1] == sml[TF32_W-1]) begin
            sum = {1'b0, ext_big} + {1'b0, aligned};
        end else begin
            sum = {1'b0, ext_big} - {1'b0, aligned};
        end

        lead = 0;
        for (int i = 0; i < MAN_W + 5; i++) begin
            if (sum[i]) begin
                lead = i;
            end
        end

        // Large cancellation only happens when diff <= 1, where no bits were lost,
        // so a plain left shift keeps the value exact.
        if (sum[MAN_W+4]) begin
            norm  = {sum[MAN_W+4:2], sum[1] | sum[0]};
            exp_i = int'(e_big) + 1;
        end else begin
            norm  = sum[MAN_W+3:0] << (13 - lead);
            exp_i = int'(e_big) - (13 - lead);
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, round_up};
        // A rounding carry turns 1.111.. into 10.000..: bump the exponent, mantissa 0.
        mant     = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        exp_i    = exp_i + int'(mant_r[MAN_W+1]);

        if (sum == '0 || exp_i <= 0) begin
            result = TF32_POS_ZERO;
        end else if (exp_i >= 255) begin
            result = {big[TF32_W-1], 8'hFF, {MAN_W{1'b0}}};
        end else begin
            result = {big[TF32_W-1], exp_i[EXP_W-1:0], mant};
        end
    end

endmodule

// File: rtl/tf32_accum_ctrl.sv
// rtl/tf32_accum_ctrl.sv - sequential TF32 reduction controller over a shared adder
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, len, abort    : job request, operand count, job cancel
//   busy                 : high whenever not IDLE
//   in_valid/in_ready/in_data    : operand stream
//   out_valid/out_ready/out_data : result handshake, out_count = operands summed
module tf32_accum_ctrl
    import tf32_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TF32_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TF32_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_count
);

    localparam logic [LEN_W-1:0] CNT_ONE = 1;

    state_t             state;
    logic [TF32_W-1:0]  acc;
    logic [TF32_W-1:0]  sum;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_nxt;
    logic [LEN_W-1:0]   len_q;

    TF32_add u_add (
        .operand_A (acc),
        .operand_B (in_data),
        .result    (sum)
    );

    // LEN_W-bit compare: with len_q at its maximum, cnt stops at len_q and never wraps.
    assign cnt_nxt   = cnt + CNT_ONE;

    assign busy      = (state != IDLE);
    assign out_data  = acc;
    assign out_count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= TF32_POS_ZERO;
            cnt       <= '0;
            len_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            acc       <= TF32_POS_ZERO;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // abort alongside start in IDLE drops the start.
                    if (start && !abort) begin
                        acc   <= TF32_POS_ZERO;
                        cnt   <= '0;
                        len_q <= len;
                        if (len != '0) begin
                            state    <= ACC;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (in_valid && in_ready) begin
                        acc <= sum;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tf32_accum_ctrl.sv
// tb/tb_tf32_accum_ctrl.sv - self-checking bench for tf32_accum_ctrl
module tb_tf32_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_data;
    logic [7:0]  out_count;

    int          n_cmp = 0;
    int          n_err = 0;
    bit [18:0]   ops[$];
    bit [18:0]   got;

    always #5 clk = ~clk;

    tf32_accum_ctrl #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Exact value as an integer in units of 2^-37 (operands stay at exponent >= 100).
    function automatic longint to_int(input bit [18:0] x);
        longint m;
        if (x[17:10] == 8'd0) return 0;
        m = longint'({1'b1, x[9:0]}) << (int'(x[17:10]) - 100);
        return x[18] ? -m : m;
    endfunction

    // Round an exact integer (units of 2^-37) to the nearest TF32, ties to even.
    function automatic bit [18:0] from_int(input longint v);
        longint a, q, rem, half;
        int     m, sh;
        bit     s;
        if (v == 0) return 19'h00000;
        s = (v < 0);
        a = s ? -v : v;
        m = 0;
        for (int b = 62; b >= 0; b--) begin
            if (a[b]) begin
                m = b;
                break;
            end
        end
        if (m > 10) begin
            sh   = m - 10;
            q    = a >> sh;
            rem  = a & ((64'sd1 <<< sh) - 1);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == 2048) begin
                q  = q >> 1;
                sh = sh + 1;
            end
        end else begin
            sh = 0;
            q  = a << (10 - m);
        end
        return {s, 8'(10 + sh + 90), q[9:0]};
    endfunction

    function automatic bit [18:0] rnd_op();
        return {1'($urandom_range(1, 0)), 8'($urandom_range(134, 120)), 10'($urandom)};
    endfunction

    // Runs one complete job from IDLE using the operands in ops; caller is at a negedge.
    task automatic do_job(input int n, input int gap_min, input int gap_max,
                          input int rdy_wait, input bit noise);
        bit [18:0] model;
        model = 19'h00000;
        foreach (ops[i]) model = from_int(to_int(model) + to_int(ops[i]));
        start = 1'b1;
        len   = 8'(n);
        @(negedge clk);
        start = 1'b0;
        chk("entry_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(gap_max, gap_min);
            in_valid = 1'b0;
            for (int k = 0; k < g; k++) begin
                if (noise) begin
                    start = 1'b1;
                    len   = 8'($urandom_range(255, 0));
                end
                @(negedge clk);
                start = 1'b0;
                chk("gap_hold_count", out_count, i);
                chk("gap_in_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            in_data  = ops[i];
            if (i == 0) chk("beat_in_ready", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("done_valid", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
        chk("done_count", out_count, n);
        chk("done_data", out_data, model);
        got = out_data;
        for (int k = 0; k < rdy_wait; k++) begin
            @(negedge clk);
            chk("hold_data", out_data, model);
            chk("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0;
        in_valid = 1'b0; in_data = 19'h0; out_ready = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        ops = '{19'h1FC00, 19'h20000, 19'h20200};
        do_job(3, 0, 0, 0, 1'b0);
        chk("t1_sum_6", got, 19'h20600);

        ops = '{19'h1FC00, 19'h5FC00};
        do_job(2, 0, 0, 1, 1'b0);
        chk("t2_cancel_pos_zero", got, 19'h00000);

        ops = '{19'h1FC00, 19'h1D000};
        do_job(2, 0, 0, 0, 1'b0);
        chk("t3_tie_even", got, 19'h1FC00);

        ops = {};
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t4_in_ready_low", in_ready, 0);
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 0);
        chk("t4_count", out_count, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_idle", busy, 0);

        ops = '{19'h1FC00, 19'h20000, 19'h20200};
        do_job(3, 4, 4, 5, 1'b1);
        chk("t5_backpressure_sum", got, 19'h20600);

        ops = '{19'h1FC00, 19'h20000, 19'h20200, 19'h1FC00};
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = ops[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_acc_clear", out_data, 0);
        chk("abort_cnt_clear", out_count, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_result", out_valid, 0);
        end

        start = 1'b1; abort = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        ops = '{19'h20000};
        do_job(1, 0, 0, 0, 1'b0);
        chk("t6_single", got, 19'h20000);

        start = 1'b1; len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 19'h20000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_abort_pre", out_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("done_abort_valid", out_valid, 0);
        chk("done_abort_busy", busy, 0);

        start = 1'b1; len = 8'd0;
        @(negedge clk);
        chk("chain_done", out_valid, 1);
        out_ready = 1'b1; start = 1'b1; len = 8'd0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("chain_start_dropped", busy, 0);
        @(negedge clk);
        start = 1'b0;
        chk("chain_next_accept", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        for (int j = 0; j < 10; j++) begin
            int n;
            n = $urandom_range(12, 1);
            ops = {};
            for (int i = 0; i < n; i++) ops.push_back(rnd_op());
            do_job(n, 0, 3, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        ops = {};
        for (int i = 0; i < 255; i++) ops.push_back(rnd_op());
        do_job(255, 0, 0, 0, 1'b0);

        start = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 19'h20000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_reset_data", out_data, 19'h20000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_data", out_data, 0);
        chk("async_rst_out_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
